// File: rtl/can_bus_pkg.sv
// Shared constants, default widths and the flip-injection state type
// for the CAN bus interconnect model.
package can_bus_pkg;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  localparam int NODES_DEF      = 3;
  localparam int DELAY_W_DEF    = 4;
  localparam int BIT_CNT_W_DEF  = 16;
  localparam int IDLE_BITS_DEF  = 11;
  localparam int STUCK_BITS_DEF = 32;
  localparam int EDGE_CNT_W_DEF = 16;

  typedef enum logic {FLIP_IDLE, FLIP_ACTIVE} flip_state_e;

  // A single node still needs a one-bit index field.
  function automatic int node_idx_w(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

endpackage

// File: rtl/can_bus_interconnect_if.sv
// Controller-side lines of the interconnect: per-node TX/RX, node enables
// and the bit-flip injection handshake.
interface can_bus_interconnect_if
  import can_bus_pkg::*;
#(
  parameter int NODES = NODES_DEF
);
  localparam int NODE_W = node_idx_w(NODES);

  logic [NODES-1:0]  tx_i;
  logic [NODES-1:0]  rx_o;
  logic [NODES-1:0]  node_en_i;
  logic              inj_flip_valid_i;
  logic [NODE_W-1:0] inj_flip_node_i;
  logic              inj_flip_ready_o;

  modport master (
    output tx_i, node_en_i, inj_flip_valid_i, inj_flip_node_i,
    input  rx_o, inj_flip_ready_o
  );

  modport slave (
    input  tx_i, node_en_i, inj_flip_valid_i, inj_flip_node_i,
    output rx_o, inj_flip_ready_o
  );

endinterface

// File: rtl/can_bus_delay_line.sv
// One node's RX delay: a recessive-initialised shift register fed by the
// registered bus, with a tap selecting 0..2^DELAY_W-1 cycles of delay.
module can_bus_delay_line
  import can_bus_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bus_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               tap_o
);
  localparam int DEPTH = (1 << DELAY_W) - 1;

  logic [DEPTH-1:0] stage_q, stage_d;
  logic [DEPTH:0]   chain;

  // chain[0] is the undelayed bus, chain[d] the bus d cycles ago.
  always_comb begin
    chain   = {stage_q, bus_i};
    stage_d = chain[DEPTH-1:0];
    tap_o   = chain[delay_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stage_q <= {DEPTH{CAN_RECESSIVE}};
    else       stage_q <= stage_d;
  end

endmodule

// File: rtl/can_bus_interconnect.sv
// N-node CAN bus model: wired-AND resolution with enables and dominant
// injection, per-node RX delay, bit-flip injection and bus supervision.
module can_bus_interconnect
  import can_bus_pkg::*;
#(
  parameter int NODES      = NODES_DEF,
  parameter int DELAY_W    = DELAY_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF,
  parameter int IDLE_BITS  = IDLE_BITS_DEF,
  parameter int STUCK_BITS = STUCK_BITS_DEF,
  parameter int EDGE_CNT_W = EDGE_CNT_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  can_bus_interconnect_if.slave    bus_if,
  input  logic [NODES*DELAY_W-1:0] delay_cfg_i,
  input  logic [BIT_CNT_W-1:0]     bit_time_i,
  input  logic                     inj_dom_i,
  output logic                     bus_o,
  output logic                     bus_idle_o,
  output logic                     stuck_dom_o,
  output logic [EDGE_CNT_W-1:0]    edge_cnt_o
);
  localparam int NODE_W = node_idx_w(NODES);
  localparam int REC_W  = $clog2(IDLE_BITS + 1);
  localparam int DOM_W  = $clog2(STUCK_BITS + 1);

  logic                  bus_q, bus_d, bus_prev_q, bus_prev_d;
  flip_state_e           state_q, state_d;
  logic [NODE_W-1:0]     flip_node_q, flip_node_d;
  logic [BIT_CNT_W-1:0]  flip_cnt_q, flip_cnt_d;
  logic [BIT_CNT_W-1:0]  cyc_q, cyc_d;
  logic [REC_W-1:0]      rec_q, rec_d;
  logic [DOM_W-1:0]      dom_q, dom_d;
  logic [EDGE_CNT_W-1:0] edge_q, edge_d;

  logic [BIT_CNT_W-1:0] bt_eff;
  logic [BIT_CNT_W:0]   cyc_nxt;
  logic                 bus_chg, bus_fall, tick, flip_ready;
  logic [NODES-1:0]     tap, rx;

  assign bt_eff = (bit_time_i == '0) ? BIT_CNT_W'(1) : bit_time_i;

  always_comb begin
    bus_d      = (&(bus_if.tx_i | ~bus_if.node_en_i)) & ~inj_dom_i;
    bus_prev_d = bus_q;
  end

  for (genvar n = 0; n < NODES; n++) begin : g_node
    can_bus_delay_line #(.DELAY_W(DELAY_W)) u_delay (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .bus_i   (bus_q),
      .delay_i (delay_cfg_i[n*DELAY_W +: DELAY_W]),
      .tap_o   (tap[n])
    );
  end

  always_comb begin
    state_d     = state_q;
    flip_node_d = flip_node_q;
    flip_cnt_d  = flip_cnt_q;
    flip_ready  = 1'b0;
    case (state_q)
      FLIP_IDLE: begin
        flip_ready = 1'b1;
        if (bus_if.inj_flip_valid_i) begin
          flip_node_d = bus_if.inj_flip_node_i;
          flip_cnt_d  = bt_eff;
          state_d     = FLIP_ACTIVE;
        end
      end
      FLIP_ACTIVE: begin
        flip_cnt_d = flip_cnt_q - BIT_CNT_W'(1);
        if (flip_cnt_q <= BIT_CNT_W'(1)) state_d = FLIP_IDLE;
      end
      default: state_d = FLIP_IDLE;
    endcase
  end

  // An out-of-range flip target matches no node and so inverts nothing.
  always_comb begin
    rx = tap;
    for (int n = 0; n < NODES; n++) begin
      if (state_q == FLIP_ACTIVE && flip_node_q == NODE_W'(n)) rx[n] = ~tap[n];
    end
  end

  always_comb begin
    bus_chg  = bus_q ^ bus_prev_q;
    bus_fall = (bus_prev_q == CAN_RECESSIVE) && (bus_q == CAN_DOMINANT);
    cyc_nxt  = {1'b0, cyc_q} + {{BIT_CNT_W{1'b0}}, 1'b1};
    tick     = cyc_nxt >= {1'b0, bt_eff};
    cyc_d    = cyc_nxt[BIT_CNT_W-1:0];
    rec_d    = rec_q;
    dom_d    = dom_q;
    edge_d   = edge_q + {{(EDGE_CNT_W-1){1'b0}}, bus_fall};
    // A level change restarts bit timing and outranks a coincident tick.
    if (bus_chg) begin
      cyc_d = '0;
      if (bus_q == CAN_RECESSIVE) dom_d = '0;
      else                        rec_d = '0;
    end else if (tick) begin
      cyc_d = '0;
      if (bus_q == CAN_RECESSIVE) begin
        if (rec_q != REC_W'(IDLE_BITS)) rec_d = rec_q + REC_W'(1);
      end else begin
        if (dom_q != DOM_W'(STUCK_BITS)) dom_d = dom_q + DOM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_q       <= CAN_RECESSIVE;
      bus_prev_q  <= CAN_RECESSIVE;
      state_q     <= FLIP_IDLE;
      flip_node_q <= '0;
      flip_cnt_q  <= '0;
      cyc_q       <= '0;
      rec_q       <= '0;
      dom_q       <= '0;
      edge_q      <= '0;
    end else begin
      bus_q       <= bus_d;
      bus_prev_q  <= bus_prev_d;
      state_q     <= state_d;
      flip_node_q <= flip_node_d;
      flip_cnt_q  <= flip_cnt_d;
      cyc_q       <= cyc_d;
      rec_q       <= rec_d;
      dom_q       <= dom_d;
      edge_q      <= edge_d;
    end
  end

  assign bus_if.rx_o             = rx;
  assign bus_if.inj_flip_ready_o = flip_ready;
  assign bus_o       = bus_q;
  assign bus_idle_o  = (rec_q == REC_W'(IDLE_BITS));
  assign stuck_dom_o = (dom_q == DOM_W'(STUCK_BITS));
  assign edge_cnt_o  = edge_q;

endmodule

// File: tb/tb_can_bus_interconnect.sv
// Directed bench for can_bus_interconnect: vector tables for resolution and
// RX delay, hand sequences for idle, stuck, enable, flip and reset cases.
module tb_can_bus_interconnect;
  import can_bus_pkg::*;

  typedef struct packed {
    logic [2:0] tx;
    logic [2:0] en;
    logic       dom;
    logic       exp_bus;
    logic [2:0] exp_rx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [11:0] delay_cfg;
  logic [15:0] bit_time;
  logic        inj_dom;
  logic        bus_o, bus_idle, stuck_dom;
  logic [15:0] edge_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t res_tab[10];
  vec_t dly_tab[14];

  can_bus_interconnect_if #(.NODES(3)) bus_if ();

  can_bus_interconnect #(.NODES(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus_if      (bus_if),
    .delay_cfg_i (delay_cfg),
    .bit_time_i  (bit_time),
    .inj_dom_i   (inj_dom),
    .bus_o       (bus_o),
    .bus_idle_o  (bus_idle),
    .stuck_dom_o (stuck_dom),
    .edge_cnt_o  (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus_if.tx_i = 3'b111;
    bus_if.node_en_i = 3'b111;
    bus_if.inj_flip_valid_i = 1'b0;
    bus_if.inj_flip_node_i = 2'd0;
    inj_dom = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    bus_if.tx_i = v.tx;
    bus_if.node_en_i = v.en;
    inj_dom = v.dom;
    @(negedge clk);
    chk($sformatf("%s[%0d].bus", tag, idx), 32'(bus_o), 32'(v.exp_bus));
    chk($sformatf("%s[%0d].rx", tag, idx), 32'(bus_if.rx_o), 32'(v.exp_rx));
  endtask

  // Cycles from reset release until bus_idle rises; 0 if it never does.
  task automatic measure_idle(output int rise, output int bad);
    rise = 0;
    bad = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (stuck_dom || edge_cnt != 16'd0) bad++;
      if (bus_idle) begin
        rise = n;
        break;
      end
    end
  endtask

  initial begin
    int rise, bad, inv;

    res_tab[0] = '{tx:3'b111, en:3'b111, dom:1'b0, exp_bus:1'b1, exp_rx:3'b111};
    res_tab[1] = '{tx:3'b101, en:3'b111, dom:1'b0, exp_bus:1'b0, exp_rx:3'b000};
    res_tab[2] = '{tx:3'b101, en:3'b101, dom:1'b0, exp_bus:1'b1, exp_rx:3'b111};
    res_tab[3] = '{tx:3'b000, en:3'b000, dom:1'b0, exp_bus:1'b1, exp_rx:3'b111};
    res_tab[4] = '{tx:3'b000, en:3'b001, dom:1'b0, exp_bus:1'b0, exp_rx:3'b000};
    res_tab[5] = '{tx:3'b111, en:3'b111, dom:1'b1, exp_bus:1'b0, exp_rx:3'b000};
    res_tab[6] = '{tx:3'b111, en:3'b000, dom:1'b1, exp_bus:1'b0, exp_rx:3'b000};
    res_tab[7] = '{tx:3'b011, en:3'b111, dom:1'b0, exp_bus:1'b0, exp_rx:3'b000};
    res_tab[8] = '{tx:3'b011, en:3'b011, dom:1'b0, exp_bus:1'b1, exp_rx:3'b111};
    res_tab[9] = '{tx:3'b111, en:3'b111, dom:1'b0, exp_bus:1'b1, exp_rx:3'b111};

    // Node1 low for rows 0..4; rx = {node2 (d=3), node1 (d=0), node0 (d=7)}.
    for (int k = 0; k < 14; k++) begin
      dly_tab[k].tx  = (k < 5) ? 3'b101 : 3'b111;
      dly_tab[k].en  = 3'b111;
      dly_tab[k].dom = 1'b0;
      dly_tab[k].exp_bus = (k < 5) ? 1'b0 : 1'b1;
    end
    dly_tab[0].exp_rx  = 3'b101; dly_tab[1].exp_rx  = 3'b101;
    dly_tab[2].exp_rx  = 3'b101; dly_tab[3].exp_rx  = 3'b001;
    dly_tab[4].exp_rx  = 3'b001; dly_tab[5].exp_rx  = 3'b011;
    dly_tab[6].exp_rx  = 3'b011; dly_tab[7].exp_rx  = 3'b010;
    dly_tab[8].exp_rx  = 3'b110; dly_tab[9].exp_rx  = 3'b110;
    dly_tab[10].exp_rx = 3'b110; dly_tab[11].exp_rx = 3'b110;
    dly_tab[12].exp_rx = 3'b111; dly_tab[13].exp_rx = 3'b111;

    rst_i = 1'b1;
    bus_if.tx_i = 3'b111;
    bus_if.node_en_i = 3'b111;
    bus_if.inj_flip_valid_i = 1'b0;
    bus_if.inj_flip_node_i = 2'd0;
    inj_dom = 1'b0;
    delay_cfg = 12'd0;
    bit_time = 16'd200;
    repeat (2) @(negedge clk);

    chk("reset.bus", 32'(bus_o), 32'd1);
    chk("reset.rx", 32'(bus_if.rx_o), 32'd7);
    chk("reset.ready", 32'(bus_if.inj_flip_ready_o), 32'd1);
    chk("reset.idle", 32'(bus_idle), 32'd0);
    chk("reset.stuck", 32'(stuck_dom), 32'd0);
    chk("reset.edge", 32'(edge_cnt), 32'd0);
    rst_i = 1'b0;

    measure_idle(rise, bad);
    chk("idle.rise_cycles", 32'(rise), 32'd2200);
    chk("idle.no_stuck_or_edge", 32'(bad), 32'd0);

    // Reset partway into an idle count; the count must start over.
    do_reset();
    repeat (1500) @(negedge clk);
    chk("idle.mid_count_low", 32'(bus_idle), 32'd0);
    #2 rst_i = 1'b1;
    #1 chk("idle.async_rst_idle", 32'(bus_idle), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    measure_idle(rise, bad);
    chk("idle.rise_after_rst", 32'(rise), 32'd2200);

    do_reset();
    for (int k = 0; k < 10; k++) run_vec(res_tab[k], "res", k);
    @(negedge clk);
    chk("res.edge_cnt", 32'(edge_cnt), 32'd2);

    do_reset();
    delay_cfg = {4'd3, 4'd0, 4'd7};
    for (int k = 0; k < 14; k++) run_vec(dly_tab[k], "dly", k);
    chk("dly.edge_cnt", 32'(edge_cnt), 32'd1);

    // Disabled node holding dominant must not disturb an idle bus.
    do_reset();
    delay_cfg = 12'd0;
    bit_time = 16'd10;
    bus_if.node_en_i = 3'b101;
    bus_if.tx_i = 3'b101;
    bad = 0;
    rise = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (bus_o != 1'b1) bad++;
      if (bus_idle) begin
        rise = n;
        break;
      end
    end
    chk("en.bus_held_recessive", 32'(bad), 32'd0);
    chk("en.idle_asserted", 32'(bus_idle), 32'd1);
    bus_if.node_en_i = 3'b111;
    @(negedge clk);
    chk("en.bus_dominant", 32'(bus_o), 32'd0);
    chk("en.idle_still_high", 32'(bus_idle), 32'd1);
    @(negedge clk);
    chk("en.idle_dropped", 32'(bus_idle), 32'd0);

    // Stuck: 1 cycle to bus_o, 1 to see the change, then 32 bits of 10 cycles.
    do_reset();
    bit_time = 16'd10;
    inj_dom = 1'b1;
    rise = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (stuck_dom) begin
        rise = n;
        break;
      end
    end
    chk("stuck.rise_cycles", 32'(rise), 32'd322);
    chk("stuck.edge_cnt", 32'(edge_cnt), 32'd1);
    inj_dom = 1'b0;
    @(negedge clk);
    chk("stuck.bus_recessive", 32'(bus_o), 32'd1);
    chk("stuck.still_set", 32'(stuck_dom), 32'd1);
    @(negedge clk);
    chk("stuck.cleared", 32'(stuck_dom), 32'd0);

    // Single-cycle flip with bit_time 0.
    do_reset();
    bit_time = 16'd0;
    bus_if.inj_flip_valid_i = 1'b1;
    bus_if.inj_flip_node_i = 2'd2;
    @(negedge clk);
    bus_if.inj_flip_valid_i = 1'b0;
    chk("flip1.rx", 32'(bus_if.rx_o), 32'd3);
    chk("flip1.ready_low", 32'(bus_if.inj_flip_ready_o), 32'd0);
    @(negedge clk);
    chk("flip1.rx_restored", 32'(bus_if.rx_o), 32'd7);
    chk("flip1.ready_high", 32'(bus_if.inj_flip_ready_o), 32'd1);

    // 50-cycle flip with a competing request that must be ignored.
    bit_time = 16'd50;
    bus_if.inj_flip_valid_i = 1'b1;
    bus_if.inj_flip_node_i = 2'd2;
    inv = 0;
    bad = 0;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (bus_if.rx_o == 3'b011 && !bus_if.inj_flip_ready_o) inv++;
      else if (bus_if.rx_o != 3'b111 || !bus_if.inj_flip_ready_o) bad++;
      if (n == 1) bus_if.inj_flip_valid_i = 1'b0;
      if (n == 10) begin
        bus_if.inj_flip_valid_i = 1'b1;
        bus_if.inj_flip_node_i = 2'd0;
      end
      if (n == 11) bus_if.inj_flip_valid_i = 1'b0;
    end
    chk("flip50.inverted_cycles", 32'(inv), 32'd50);
    chk("flip50.unexpected_states", 32'(bad), 32'd0);

    // Out-of-range target is accepted but leaves every rx alone.
    bit_time = 16'd0;
    bus_if.inj_flip_valid_i = 1'b1;
    bus_if.inj_flip_node_i = 2'd3;
    @(negedge clk);
    bus_if.inj_flip_valid_i = 1'b0;
    chk("flip_oor.ready_low", 32'(bus_if.inj_flip_ready_o), 32'd0);
    chk("flip_oor.rx", 32'(bus_if.rx_o), 32'd7);
    @(negedge clk);
    chk("flip_oor.ready_high", 32'(bus_if.inj_flip_ready_o), 32'd1);

    // Flip over an injected dominant bus: target reads recessive.
    inj_dom = 1'b1;
    repeat (2) @(negedge clk);
    bit_time = 16'd5;
    bus_if.inj_flip_valid_i = 1'b1;
    bus_if.inj_flip_node_i = 2'd0;
    @(negedge clk);
    bus_if.inj_flip_valid_i = 1'b0;
    chk("dom_flip.rx", 32'(bus_if.rx_o), 32'd1);
    inj_dom = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a flip.
    bit_time = 16'd50;
    bus_if.inj_flip_valid_i = 1'b1;
    bus_if.inj_flip_node_i = 2'd2;
    @(negedge clk);
    bus_if.inj_flip_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_flip.rx_before", 32'(bus_if.rx_o), 32'd3);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_flip.rx", 32'(bus_if.rx_o), 32'd7);
    chk("rst_flip.ready", 32'(bus_if.inj_flip_ready_o), 32'd1);
    chk("rst_flip.edge", 32'(edge_cnt), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_flip.rx_after", 32'(bus_if.rx_o), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
